// File: rtl/ntt_ctrl.sv
// ntt_ctrl: radix-2 NTT address sequencer with write-back delay line; define NTT_CTRL_PERF_EN to add stall_cnt.
module ntt_ctrl #(
    parameter int LOG_N = 8,
    parameter int LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic [4:0]       stage,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_u,
    output logic [LOG_N-1:0] rd_addr_v,
    output logic [LOG_N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_u,
    output logic [LOG_N-1:0] wr_addr_v
`ifdef NTT_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);
    localparam int JW = LOG_N - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_n;
    logic [4:0] s, s_n;
    logic [JW-1:0] j, j_n, k;
    logic [2:0] dc, dc_n;
    logic [LOG_N-1:0] jx, half;
    logic dv [LAT];
    logic [LOG_N-1:0] du [LAT];
    logic [LOG_N-1:0] dw [LAT];

    always_comb begin
        state_n = state;
        s_n = s;
        j_n = j;
        dc_n = dc;
        unique case (state)
            IDLE: if (start) begin
                state_n = RUN;
                s_n = '0;
                j_n = '0;
            end
            RUN: if (!stall) begin
                if (&j) begin
                    state_n = DRAIN;
                    dc_n = '0;
                end else j_n = j + 1'b1;
            end
            DRAIN: if (!stall) begin
                if (dc != 3'(LAT - 1)) dc_n = dc + 1'b1;
                else if (s == 5'(LOG_N - 1)) state_n = DONE;
                else begin
                    state_n = RUN;
                    s_n = s + 1'b1;
                    j_n = '0;
                end
            end
            DONE: begin
                state_n = IDLE;
                s_n = '0;
            end
        endcase
    end

    // u = group base (g * 2 * half) plus offset k inside the group; v sits half above it
    assign jx = {1'b0, j};
    assign half = LOG_N'(1) << s;
    assign k = j & ~({JW{1'b1}} << s);
    assign rd_en = state == RUN && !stall;
    assign rd_addr_u = state == RUN ? ((jx >> s) << (s + 5'd1)) | {1'b0, k} : '0;
    assign rd_addr_v = state == RUN ? rd_addr_u | half : '0;
    assign tw_addr = state == RUN ? k << (5'(JW) - s) : '0;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign stage = s;
    assign wr_en = dv[LAT-1] && !stall;
    assign wr_addr_u = du[LAT-1];
    assign wr_addr_v = dw[LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s <= '0;
            j <= '0;
            dc <= '0;
            for (int i = 0; i < LAT; i++) begin
                dv[i] <= 1'b0;
                du[i] <= '0;
                dw[i] <= '0;
            end
        end else begin
            state <= state_n;
            s <= s_n;
            j <= j_n;
            dc <= dc_n;
            if (!stall) begin
                dv[0] <= rd_en;
                du[0] <= rd_addr_u;
                dw[0] <= rd_addr_v;
                for (int i = 1; i < LAT; i++) begin
                    dv[i] <= dv[i-1];
                    du[i] <= du[i-1];
                    dw[i] <= dw[i-1];
                end
            end
        end
    end

`ifdef NTT_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt <= '0;
        else if (state == IDLE && start) stall_cnt <= '0;
        else if (busy && stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
`endif
endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer for an in-place radix-2 Cooley-Tukey NTT over an N = 2^LOG_N coefficient memory, driving one combinational butterfly unit, i.e. the mod_mult / mod_add / mod_sub datapath. It generates per-cycle read addresses for the (u, v) operand pair and the twiddle index, delays them by the fixed read+butterfly latency to produce write-back addresses, and inserts a pipeline drain between stages so no stage reads a coefficient before the previous stage has written it. It sits between the NTT command decoder (start/done) and the coefficient RAM, twiddle ROM and butterfly.

## Interface
Parameters:
- LOG_N, 8: log2 of transform size; legal range 2..16.
- LAT, 2: cycles from read issue to write-back of the same pair (RAM read latency + butterfly register stages); legal range 1..8.

Ports (reset is asynchronous, active-high; one clock):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle request to begin a transform; accepted only in IDLE.
- stall  in  1  global freeze: holds issue, delay line, drain counter and stage/index counters.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at the end of the transform.
- stage  out  5  current stage index s (0..LOG_N-1).
- rd_en  out  1  read/issue strobe for the operand pair.
- rd_addr_u, rd_addr_v  out  LOG_N  operand addresses.
- tw_addr  out  LOG_N-1  twiddle ROM index (table of N/2 powers of the root).
- wr_en  out  1  write-back strobe.
- wr_addr_u, wr_addr_v  out  LOG_N  write-back addresses (rd addresses delayed LAT un-stalled cycles).

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN, s=0, j=0. start in any other state ignored.
- RUN: butterfly index j counts 0..N/2-1, one per un-stalled cycle. half = 2^s, k = j & (half-1), g = j >> s. rd_addr_u = 2·g·half + k; rd_addr_v = rd_addr_u + half; tw_addr = k << (LOG_N-1-s). rd_en = (state==RUN) && !stall. After issuing j = N/2-1 -> DRAIN.
- DRAIN: counter runs LAT un-stalled cycles, rd_en=0. At end: s < LOG_N-1 -> s+1, j=0, RUN; else -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Delay line: LAT-deep shift register of {valid, addr_u, addr_v}, shifts only when !stall. wr_en = tail valid && !stall; wr_addr_* = tail addresses.
- All arithmetic unsigned, widths above; address math never overflows for legal LOG_N.
- stall in IDLE/DONE: no effect on transitions (DONE still lasts one cycle).
- rst mid-operation: immediate return to IDLE, delay line cleared; in-flight writes discarded.

## Timing
- Reset values: busy=0, done=0, stage=0, rd_en=0, rd_addr_u=0, rd_addr_v=0, tw_addr=0, wr_en=0, wr_addr_u=0, wr_addr_v=0.
- start sampled at edge 0 -> first rd_en in cycle 1.
- Write of an issue made in cycle t appears in cycle t+LAT (no stall).
- First read of stage s+1 occurs one cycle after last write of stage s.
- Unstalled total: done high in cycle 1 + LOG_N·(N/2 + LAT); busy high cycles 1 through that cycle inclusive.
- Each stall cycle adds exactly one cycle to the total.

## Configuration
- NTT_CTRL_PERF_EN defined: adds output stall_cnt [31:0], counting cycles with busy && stall; cleared to 0 on accepted start and on rst; saturates at 0xFFFFFFFF; holds value after done.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- LOG_N=3, LAT=2, start, no stall -> stage 0 reads (u,v,tw): (0,1,0)(2,3,0)(4,5,0)(6,7,0); stage 1: (0,2,0)(1,3,2)(4,6,0)(5,7,2); stage 2: (0,4,0)(1,5,1)(2,6,2)(3,7,3); done in cycle 19.
- Same config: each write pair equals the read pair issued 2 cycles earlier; no stage-s+1 read precedes the last stage-s write; 12 rd_en and 12 wr_en total.
- Stall held 3 cycles mid-RUN of stage 1 and 2 cycles in DRAIN -> outputs frozen, sequence unchanged, done in cycle 24; with NTT_CTRL_PERF_EN stall_cnt=5.
- start pulsed during RUN -> ignored, single done pulse, sequence unchanged.
- rst asserted during stage 1 -> all outputs 0 immediately; new start restarts at stage 0, address (0,1,0).
- LOG_N=8, LAT=4 -> last stage reads (127,255,127); done in cycle 1+8·132=1057.
